// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop rx sync, oversampled mid-bit sampling, FWFT rx FIFO.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            rx,
  input  logic [DIV_W-1:0]                clk_div,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            rx_busy,
  output logic                            frame_err,
  output logic                            overrun,
  input  logic                            err_clr
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  output logic                            parity_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] HALF  = SW'(OVERSAMPLE/2-1);
  localparam logic [SW-1:0] FULL  = SW'(OVERSAMPLE-1);
  localparam logic [BW-1:0] LASTB = BW'(DATA_BITS-1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t               state;
  logic                 rx_m, rx_s, rx_d;
  logic                 fall, tick;
  logic [DIV_W-1:0]     tcnt;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic                 stop_smp, push, pop, full, push_ok;

  assign fall     = rx_d & ~rx_s;
  assign tick     = (tcnt == clk_div);
  assign rx_busy  = (state != S_IDLE);
  assign stop_smp = (state == S_STOP) && tick && (scnt == FULL);
  assign push     = stop_smp && rx_s && !par_bad;
  assign rx_valid = (fifo_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (fifo_count == DEPTH);
  assign push_ok  = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rptr] : '0;

  // Bring rx into the clock domain and keep one extra stage for edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Baud tick counter, realigned to the frame on the start edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcnt <= '0;
    end else if ((state == S_IDLE) && fall) begin
      tcnt <= '0;
    end else if (tcnt >= clk_div) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame FSM: start qualify, data shift, optional parity, stop check
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            scnt  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (scnt == HALF) begin
              scnt <= '0;
              if (rx_s) begin
                state <= S_IDLE;
              end else begin
                state   <= S_DATA;
                bidx    <= '0;
                par_bad <= 1'b0;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (scnt == FULL) begin
              scnt  <= '0;
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bidx == LASTB) begin
`ifdef UART_RX_PARITY_EN
                state <= parity_en ? S_PAR : S_STOP;
`else
                state <= S_STOP;
`endif
              end else begin
                bidx <= bidx + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (tick) begin
            if (scnt == FULL) begin
              scnt  <= '0;
              state <= S_STOP;
              if (rx_s != (^shreg ^ parity_odd)) begin
                par_bad    <= 1'b1;
                parity_err <= 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (scnt == FULL) begin
              scnt  <= '0;
              state <= S_IDLE;
              if (!rx_s) frame_err <= 1'b1;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage; output is gated so unwritten entries never leak out
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overrun
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo.
// Expected bytes come from a queue model of the serial frames sent.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx;
  logic [15:0] clk_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  fifo_count;
  logic        rx_busy;
  logic        frame_err;
  logic        overrun;
  logic        err_clr;
`ifdef UART_RX_PARITY_EN
  logic        parity_en;
  logic        parity_odd;
  logic        parity_err;
  int          pe_cnt = 0;
`endif

  int          total = 0;
  int          bad = 0;
  int          fe_cnt = 0;
  logic [7:0]  q[$];
  logic        exp_ovr = 1'b0;

  uart_rx_fifo dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .clk_div    (clk_div),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .parity_err (parity_err)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end
`ifdef UART_RX_PARITY_EN
  always @(posedge clk) begin
    if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
  end
`endif

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      repeat (16 * (int'(clk_div) + 1)) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits({1'b1, stop, b, 1'b0}, 10);
    if (!stop) begin
      rx = 1'b1;
      repeat (2 * (int'(clk_div) + 1)) @(negedge clk);
    end else if (q.size() < 8) begin
      q.push_back(b);
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_valid, rx_data, fifo_count, rx_busy, frame_err, overrun} !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold outs=%h want 0",
        {rx_valid, rx_data, fifo_count, rx_busy, frame_err, overrun});
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({rx_valid, fifo_count, rx_busy, overrun} !== 7'h0) begin
      bad++;
      $display("FAIL reset_release v=%b cnt=%0d busy=%b ovr=%b want 0",
        rx_valid, fifo_count, rx_busy, overrun);
    end
  endtask

  task automatic test_basic();
    int fe0;
    int lat;
    clk_div = 16'd26;
    fe0 = fe_cnt;
    lat = 3 + 152 * (int'(clk_div) + 1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        #1;
        total++;
        if (rx_valid !== 1'b0) begin
          bad++;
          $display("FAIL basic_early rx_valid=%b want 0", rx_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h55) begin
          bad++;
          $display("FAIL basic_latency v=%b d=%h want 1 55", rx_valid, rx_data);
        end
      end
    join
    total++;
    if (fifo_count !== 4'(q.size()) || fe_cnt != fe0) begin
      bad++;
      $display("FAIL basic_count cnt=%0d fe=%0d want %0d 0",
        fifo_count, fe_cnt - fe0, q.size());
    end
    while (q.size() > 0) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
        bad++;
        $display("FAIL basic_pop v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_glitch();
    int fe0;
    clk_div = 16'd4;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4 * 5) @(negedge clk);
    total++;
    if (rx_busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy rx_busy=%b want 1", rx_busy);
    end
    rx = 1'b1;
    repeat (12 * 5) @(negedge clk);
    total++;
    if (rx_busy !== 1'b0 || fifo_count !== 4'd0 || fe_cnt != fe0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL glitch_idle busy=%b cnt=%0d fe=%0d ovr=%b want 0 0 0 0",
        rx_busy, fifo_count, fe_cnt - fe0, overrun);
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    clk_div = 16'd4;
    fe0 = fe_cnt;
    send_frame(8'hA3, 1'b0);
    total++;
    if (fe_cnt - fe0 != 1 || fifo_count !== 4'(q.size())) begin
      bad++;
      $display("FAIL frame_err pulses=%0d cnt=%0d want 1 %0d",
        fe_cnt - fe0, fifo_count, q.size());
    end
    send_frame(8'h3C, 1'b1);
    while (q.size() > 0) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
        bad++;
        $display("FAIL ferr_pop v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_overrun();
    clk_div = 16'd4;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    total++;
    if (overrun !== exp_ovr || fifo_count !== 4'(q.size())) begin
      bad++;
      $display("FAIL overrun_set ovr=%b cnt=%0d want %b %0d",
        overrun, fifo_count, exp_ovr, q.size());
    end
    while (q.size() > 0) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
        bad++;
        $display("FAIL ovr_pop v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(q.pop_front());
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky ovr=%b want 1", overrun);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clr ovr=%b want 0", overrun);
    end
  endtask

  task automatic test_full_pop();
    int lat;
    clk_div = 16'd2;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1);
    lat = 3 + 152 * (int'(clk_div) + 1);
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        total++;
        if (rx_data !== q[0] || fifo_count !== 4'd8) begin
          bad++;
          $display("FAIL full_head d=%h cnt=%0d want %h 8", rx_data, fifo_count, q[0]);
        end
        rx_ready = 1'b1;
        void'(q.pop_front());
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    total++;
    if (overrun !== exp_ovr || fifo_count !== 4'(q.size())) begin
      bad++;
      $display("FAIL full_pop ovr=%b cnt=%0d want %b %0d",
        overrun, fifo_count, exp_ovr, q.size());
    end
    while (q.size() > 0) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
        bad++;
        $display("FAIL full_drain v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    clk_div = 16'd4;
    send_frame(8'h5A, 1'b1);
    send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 5);
    resetn = 1'b0;
    rx = 1'b1;
    q.delete();
    exp_ovr = 1'b0;
    @(negedge clk);
    total++;
    if ({rx_valid, rx_data, fifo_count, rx_busy, frame_err, overrun} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid outs=%h want 0",
        {rx_valid, rx_data, fifo_count, rx_busy, frame_err, overrun});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h12, 1'b1);
    total++;
    if (fifo_count !== 4'(q.size()) || rx_data !== q[0]) begin
      bad++;
      $display("FAIL reset_next cnt=%0d d=%h want %0d %h",
        fifo_count, rx_data, q.size(), q[0]);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_div0();
    logic [7:0] b;
    clk_div = 16'd0;
    b = 8'($urandom);
    send_frame(b, 1'b1);
    total++;
    if (fifo_count !== 4'(q.size()) || rx_data !== b) begin
      bad++;
      $display("FAIL div0 cnt=%0d d=%h want %0d %h", fifo_count, rx_data, q.size(), b);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int         fe0;
    for (int n = 0; n < 20; n++) begin
      clk_div = 16'($urandom_range(0, 5));
      b = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      fe0 = fe_cnt;
      send_frame(b, stop);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      total++;
      if (fifo_count !== 4'(q.size()) || overrun !== exp_ovr
          || (fe_cnt - fe0) != int'(!stop)) begin
        bad++;
        $display("FAIL rand_frame n=%0d cnt=%0d ovr=%b fe=%0d want %0d %b %0d",
          n, fifo_count, overrun, fe_cnt - fe0, q.size(), exp_ovr, int'(!stop));
      end
      if (exp_ovr) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        while (q.size() > 0) begin
          total++;
          if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
            bad++;
            $display("FAIL rand_pop v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
          end
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
          void'(q.pop_front());
        end
      end
    end
    while (q.size() > 0) begin
      total++;
      if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
        bad++;
        $display("FAIL rand_drain v=%b d=%h want 1 %h", rx_valid, rx_data, q[0]);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      void'(q.pop_front());
    end
    total++;
    if (rx_valid !== 1'b0 || fifo_count !== 4'd0) begin
      bad++;
      $display("FAIL rand_empty v=%b cnt=%0d want 0 0", rx_valid, fifo_count);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int pe0;
    logic [7:0] b;
    clk_div = 16'd4;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    b = 8'h07;
    pe0 = pe_cnt;
    send_bits({1'b1, 1'b0, b, 1'b0}, 11);
    total++;
    if (pe_cnt - pe0 != 1 || fifo_count !== 4'(q.size())) begin
      bad++;
      $display("FAIL parity_bad pe=%0d cnt=%0d want 1 %0d", pe_cnt - pe0, fifo_count, q.size());
    end
    pe0 = pe_cnt;
    send_bits({1'b1, ^b, b, 1'b0}, 11);
    q.push_back(b);
    total++;
    if (pe_cnt != pe0 || fifo_count !== 4'(q.size()) || rx_data !== q[0]) begin
      bad++;
      $display("FAIL parity_good pe=%0d cnt=%0d d=%h want 0 %0d %h",
        pe_cnt - pe0, fifo_count, rx_data, q.size(), q[0]);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q.pop_front());
    parity_en = 1'b0;
  endtask
`endif

  initial begin
    rx       = 1'b1;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    clk_div  = 16'd26;
    resetn   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_en  = 1'b0;
    parity_odd = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    test_div0();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
